// File: rtl/serial_bcs_comparator.sv
// serial_bcs_comparator
//   Bit-serial unsigned magnitude comparator. Operands are loaded on an
//   accepted start and processed MSB first, one bit pair per cycle, using
//   a chained equal/greater slice. Results: e = (A == B), g = (B > A).
//
//   Optional build macro: EARLY_EXIT_EN
//     defined   -> finish on the first differing bit pair
//     undefined -> always process all N bit pairs
//
//   state | meaning
//   IDLE  | waiting for start, e/g hold the last result
//   SHIFT | processing one bit pair per cycle, busy=1
//   DONE  | one-cycle done pulse, start here begins a new compare
module serial_bcs_comparator #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic         e,
  output logic         g
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           e_q, e_d;
  logic           g_q, g_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           last_bit;
  logic           finish;

  assign last_bit = (cnt_q == CW'(N - 1));

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    g_d     = g_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          e_d     = 1'b1;
          g_d     = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // g uses the pre-update e so only the first difference decides it
        e_d   = e_q & ~(a_q[N-1] ^ b_q[N-1]);
        g_d   = g_q | (e_q & b_q[N-1] & ~a_q[N-1]);
        a_d   = {a_q[N-2:0], 1'b0};
        b_d   = {b_q[N-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
`ifdef EARLY_EXIT_EN
        finish = last_bit | ~e_d;
`else
        finish = last_bit;
`endif
        if (finish) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      g_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      g_q     <= g_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign e    = e_q;
  assign g    = g_q;

endmodule

// File: tb/tb_serial_bcs_comparator.sv
// Directed-vector bench for serial_bcs_comparator (N=8).
// Expected latencies follow the EARLY_EXIT_EN build setting.
module tb_serial_bcs_comparator;

  localparam int N = 8;

`ifdef EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic         busy;
  logic         done;
  logic         e;
  logic         g;

  int checks;
  int failures;

  serial_bcs_comparator #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .e     (e),
    .g     (g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply operands with start for one edge; returns 1 ns after that edge.
  task automatic pulse_start(input logic [N-1:0] a, input logic [N-1:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called 1 ns after the accepting edge. lat = cycle index of done
  // (1 = cycle right after the accept edge); 99 if done never came.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (done !== 1'b1) lat = 99;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    a_in  = 8'h00;
    b_in  = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL reset_e got=%b exp=0", e); end
    checks++; if (g !== 1'b0) begin failures++; $display("FAIL reset_g got=%b exp=0", g); end
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_equal();
    int lat, bc;
    pulse_start(8'h5A, 8'h5A);
    wait_done(lat, bc);
    checks++; if (lat != 9) begin failures++; $display("FAIL eq_latency got=%0d exp=9", lat); end
    checks++; if (bc != 8) begin failures++; $display("FAIL eq_busy_cycles got=%0d exp=8", bc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL eq_busy_in_done got=%b exp=0", busy); end
    checks++; if (e !== 1'b1 || g !== 1'b0) begin failures++; $display("FAIL eq_result got e=%b g=%b exp e=1 g=0", e, g); end
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL eq_done_one_cycle got=%b exp=0", done); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (e !== 1'b1 || g !== 1'b0) begin failures++; $display("FAIL eq_hold got e=%b g=%b exp e=1 g=0", e, g); end
  endtask

  task automatic test_greater();
    int lat, bc;
    int exp_lat;
    exp_lat = EE ? 2 : 9;
    pulse_start(8'h10, 8'h80);
    wait_done(lat, bc);
    checks++; if (lat != exp_lat) begin failures++; $display("FAIL gt_latency got=%0d exp=%0d", lat, exp_lat); end
    checks++; if (e !== 1'b0 || g !== 1'b1) begin failures++; $display("FAIL gt_result got e=%b g=%b exp e=0 g=1", e, g); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_less();
    int lat, bc;
    int exp_lat;
    exp_lat = EE ? 2 : 9;
    pulse_start(8'hFF, 8'h00);
    wait_done(lat, bc);
    checks++; if (lat != exp_lat) begin failures++; $display("FAIL lt_latency got=%0d exp=%0d", lat, exp_lat); end
    checks++; if (e !== 1'b0 || g !== 1'b0) begin failures++; $display("FAIL lt_result got e=%b g=%b exp e=0 g=0", e, g); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_last_bit();
    int lat, bc;
    pulse_start(8'h00, 8'h01);
    wait_done(lat, bc);
    checks++; if (lat != 9) begin failures++; $display("FAIL lsb_latency got=%0d exp=9", lat); end
    checks++; if (e !== 1'b0 || g !== 1'b1) begin failures++; $display("FAIL lsb_result got e=%b g=%b exp e=0 g=1", e, g); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_start();
    int lat, bc;
    pulse_start(8'h33, 8'h33);
    repeat (2) @(posedge clk);
    #1;
    pulse_start(8'h00, 8'hFF);
    wait_done(lat, bc);
    // accept edge + 2 + 1 edges already consumed before wait_done
    lat = lat + 3;
    checks++; if (lat != 9) begin failures++; $display("FAIL ign_latency got=%0d exp=9", lat); end
    checks++; if (e !== 1'b1 || g !== 1'b0) begin failures++; $display("FAIL ign_result got e=%b g=%b exp e=1 g=0", e, g); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    int exp_lat;
    bit saw_done;
    pulse_start(8'h5A, 8'h5A);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || e !== 1'b0 || g !== 1'b0)
      begin failures++; $display("FAIL rstmid_outputs got busy=%b done=%b e=%b g=%b exp all 0", busy, done, e, g); end
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++; if (saw_done) begin failures++; $display("FAIL rstmid_no_activity got=1 exp=0"); end
    exp_lat = EE ? 4 : 9;
    pulse_start(8'h12, 8'h34);
    wait_done(lat, bc);
    checks++; if (lat != exp_lat) begin failures++; $display("FAIL rstmid_fresh_latency got=%0d exp=%0d", lat, exp_lat); end
    checks++; if (e !== 1'b0 || g !== 1'b1) begin failures++; $display("FAIL rstmid_fresh_result got e=%b g=%b exp e=0 g=1", e, g); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    int exp_lat;
    exp_lat = EE ? 8 : 9;
    a_in  = 8'h01;
    b_in  = 8'h02;
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(lat, bc);
    checks++; if (lat != exp_lat) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=%0d", lat, exp_lat); end
    checks++; if (e !== 1'b0 || g !== 1'b1) begin failures++; $display("FAIL b2b_first_result got e=%b g=%b exp e=0 g=1", e, g); end
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0)
      begin failures++; $display("FAIL b2b_restart got busy=%b done=%b exp busy=1 done=0", busy, done); end
    wait_done(lat, bc);
    checks++; if (lat != exp_lat) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat, exp_lat); end
    checks++; if (e !== 1'b0 || g !== 1'b1) begin failures++; $display("FAIL b2b_second_result got e=%b g=%b exp e=0 g=1", e, g); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a_in     = '0;
    b_in     = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_equal();
    test_greater();
    test_less();
    test_last_bit();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
